// File: rtl/ycc_pkg.sv
// Shared constants and FSM state type for the YCrCb sequencing controller.
package ycc_pkg;

    localparam int DATA_NUM = 4;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_Y    = 2'b01;
    localparam logic [1:0] MODE_CR   = 2'b10;
    localparam logic [1:0] MODE_CB   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PY,
        PCR,
        PCB,
        DRAIN,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/ycc_seq_ctrl.sv
// Sequencer that feeds one RGB pixel group at a time through an external
// toYCrCb converter (Y, then Cr, then Cb pass) and presents the three
// captured results as one output group. Every output is a register that is
// updated on the same edge as the state change into the state it belongs to.
module ycc_seq_ctrl
    import ycc_pkg::*;
#(
    parameter int DATA_NUM = ycc_pkg::DATA_NUM,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cfg_start,
    input  logic [CNT_W-1:0]      cfg_num_groups,

    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [8*DATA_NUM-1:0] pix_R,
    input  logic [8*DATA_NUM-1:0] pix_G,
    input  logic [8*DATA_NUM-1:0] pix_B,

    output logic                  conv_start,
    output logic [1:0]            conv_mode,
    output logic [8*DATA_NUM-1:0] conv_R,
    output logic [8*DATA_NUM-1:0] conv_G,
    output logic [8*DATA_NUM-1:0] conv_B,
    input  logic                  conv_finish,
    input  logic [8*DATA_NUM-1:0] conv_out,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*DATA_NUM-1:0] out_Y,
    output logic [8*DATA_NUM-1:0] out_Cr,
    output logic [8*DATA_NUM-1:0] out_Cb,

    output logic                  busy,
    output logic                  done
);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_numGroups;
    logic [8*DATA_NUM-1:0]   r_convR;
    logic [8*DATA_NUM-1:0]   r_convG;
    logic [8*DATA_NUM-1:0]   r_convB;
    logic [8*DATA_NUM-1:0]   r_outY;
    logic [8*DATA_NUM-1:0]   r_outCr;
    logic [8*DATA_NUM-1:0]   r_outCb;
    logic                    r_pixReady;
    logic                    r_convStart;
    logic [1:0]              r_convMode;
    logic                    r_outValid;
    logic                    r_busy;
    logic                    r_done;

    logic [CNT_W-1:0]        w_countNext;

    assign w_countNext = r_count + CNT_W'(1);

    // Sequencer FSM: each branch sets the registered outputs for the state it moves into.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_numGroups <= '0;
            r_convR     <= '0;
            r_convG     <= '0;
            r_convB     <= '0;
            r_outY      <= '0;
            r_outCr     <= '0;
            r_outCb     <= '0;
            r_pixReady  <= 1'b0;
            r_convStart <= 1'b0;
            r_convMode  <= MODE_IDLE;
            r_outValid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pixReady  <= 1'b0;
            r_convStart <= 1'b0;
            r_convMode  <= MODE_IDLE;
            r_done      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_numGroups <= cfg_num_groups;
                        r_count     <= '0;
                        if (cfg_num_groups == '0) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_busy     <= 1'b1;
                            r_pixReady <= 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (pix_valid) begin
                        r_convR     <= pix_R;
                        r_convG     <= pix_G;
                        r_convB     <= pix_B;
                        r_convStart <= 1'b1;
                        r_convMode  <= MODE_Y;
                        r_state     <= PY;
                    end else begin
                        r_pixReady <= 1'b1;
                    end
                end

                PY: begin
                    r_convStart <= 1'b1;
                    r_convMode  <= MODE_CR;
                    r_state     <= PCR;
                end

                PCR: begin
                    if (conv_finish) begin
                        r_outY      <= conv_out;
                        r_convStart <= 1'b1;
                        r_convMode  <= MODE_CB;
                        r_state     <= PCB;
                    end else begin
                        r_convMode <= MODE_CR;
                    end
                end

                PCB: begin
                    if (conv_finish) begin
                        r_outCr <= conv_out;
                        r_state <= DRAIN;
                    end else begin
                        r_convMode <= MODE_CB;
                    end
                end

                DRAIN: begin
                    if (conv_finish) begin
                        r_outCb    <= conv_out;
                        r_outValid <= 1'b1;
                        r_state    <= OUT;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_count    <= w_countNext;
                        if (w_countNext == r_numGroups) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_pixReady <= 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pix_ready  = r_pixReady;
    assign conv_start = r_convStart;
    assign conv_mode  = r_convMode;
    assign conv_R     = r_convR;
    assign conv_G     = r_convG;
    assign conv_B     = r_convB;
    assign out_valid  = r_outValid;
    assign out_Y      = r_outY;
    assign out_Cr     = r_outCr;
    assign out_Cb     = r_outCb;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
